// File: rtl/apb_cmd_master.sv
// apb_cmd_master: command-to-APB master with registered bus outputs, back-to-back issue and an ACCESS-phase timeout.
module apb_cmd_master #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 12
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_strb,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              tim_psel,
  output logic              tim_penable,
  output logic              tim_pwrite,
  output logic [ADDR_W-1:0] tim_paddr,
  output logic [31:0]       tim_pwdata,
  output logic [3:0]        tim_pstrb,
  input  logic              tim_pready,
  input  logic              tim_pslverr,
  input  logic [31:0]       tim_prdata
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t r_state, w_state;
  logic r_psel, w_psel, r_pen, w_pen, r_pwrite, w_pwrite;
  logic [ADDR_W-1:0] r_paddr, w_paddr;
  logic [31:0] r_pwdata, w_pwdata, r_rdata, w_rdata;
  logic [3:0] r_pstrb, w_pstrb;
  logic [7:0] r_cnt, w_cnt, w_inc;
  logic r_rv, w_rv, r_err, w_err, r_to, w_to;
  logic w_acc, w_done, w_tmo;
  assign cmd_ready = !sys_rst && (r_state == IDLE || (r_state == ACCESS && tim_pready));
  assign w_acc = cmd_valid && cmd_ready;
  assign w_done = r_state == ACCESS && tim_pready;
  assign w_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
  assign w_tmo = r_state == ACCESS && !tim_pready && TIMEOUT != 0 && 32'(w_inc) >= TIMEOUT;
  always_comb begin
    w_state = r_state;
    w_psel = r_psel;
    w_pen = r_pen;
    w_pwrite = r_pwrite;
    w_paddr = r_paddr;
    w_pwdata = r_pwdata;
    w_pstrb = r_pstrb;
    w_cnt = r_cnt;
    w_rv = 1'b0;
    w_to = 1'b0;
    w_err = r_err;
    w_rdata = r_rdata;
    if (r_state == SETUP) begin
      w_pen = 1'b1;
      w_state = ACCESS;
    end
    if (r_state == ACCESS && !tim_pready) w_cnt = w_inc;
    // Completion and abort both release the bus; a new accept below overrides it.
    if (w_done || w_tmo) begin
      w_state = IDLE;
      w_psel = 1'b0;
      w_pen = 1'b0;
      w_pwrite = 1'b0;
      w_paddr = '0;
      w_pwdata = '0;
      w_pstrb = '0;
      w_rv = 1'b1;
      w_to = w_tmo;
      w_err = w_tmo || tim_pslverr;
      w_rdata = (w_done && !r_pwrite && !tim_pslverr) ? tim_prdata : 32'd0;
    end
    if (w_acc) begin
      w_state = SETUP;
      w_psel = 1'b1;
      w_pen = 1'b0;
      w_pwrite = cmd_write;
      w_paddr = cmd_addr;
      w_pwdata = cmd_wdata;
      w_pstrb = cmd_write ? cmd_strb : 4'd0;
      w_cnt = '0;
    end
  end
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= IDLE;
      r_psel <= 1'b0;
      r_pen <= 1'b0;
      r_pwrite <= 1'b0;
      r_paddr <= '0;
      r_pwdata <= '0;
      r_pstrb <= '0;
      r_cnt <= '0;
      r_rv <= 1'b0;
      r_to <= 1'b0;
      r_err <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state;
      r_psel <= w_psel;
      r_pen <= w_pen;
      r_pwrite <= w_pwrite;
      r_paddr <= w_paddr;
      r_pwdata <= w_pwdata;
      r_pstrb <= w_pstrb;
      r_cnt <= w_cnt;
      r_rv <= w_rv;
      r_to <= w_to;
      r_err <= w_err;
      r_rdata <= w_rdata;
    end
  end
  assign tim_psel = r_psel;
  assign tim_penable = r_pen;
  assign tim_pwrite = r_pwrite;
  assign tim_paddr = r_paddr;
  assign tim_pwdata = r_pwdata;
  assign tim_pstrb = r_pstrb;
  assign rsp_valid = r_rv;
  assign rsp_timeout = r_to;
  assign rsp_err = r_err;
  assign rsp_rdata = r_rdata;
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: directed self-checking bench for apb_cmd_master with default parameters.
module tb_apb_cmd_master;
  logic sys_clk = 1'b0, sys_rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [11:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0] cmd_strb = '0;
  logic rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic tim_psel, tim_penable, tim_pwrite;
  logic [11:0] tim_paddr;
  logic [31:0] tim_pwdata;
  logic [3:0] tim_pstrb;
  logic tim_pready = 1'b0, tim_pslverr = 1'b0;
  logic [31:0] tim_prdata = '0;
  int checks = 0, failures = 0, n;
  apb_cmd_master dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .tim_psel(tim_psel), .tim_penable(tim_penable), .tim_pwrite(tim_pwrite),
    .tim_paddr(tim_paddr), .tim_pwdata(tim_pwdata), .tim_pstrb(tim_pstrb),
    .tim_pready(tim_pready), .tim_pslverr(tim_pslverr), .tim_prdata(tim_prdata)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cmd(input logic w, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr = a;
    cmd_wdata = d;
    cmd_strb = s;
  endtask
  initial begin
    tick();
    chk("rst_ready", 32'(cmd_ready), 0);
    chk("rst_psel", 32'(tim_psel), 0);
    chk("rst_rv", 32'(rsp_valid), 0);
    sys_rst = 1'b0;
    tick();
    chk("post_rst_ready", 32'(cmd_ready), 1);
    tim_pready = 1'b1;
    cmd(1'b1, 12'h00C, 32'h12345678, 4'hF);
    tick();
    cmd_valid = 1'b0;
    chk("w_setup_psel", 32'(tim_psel), 1);
    chk("w_setup_pen", 32'(tim_penable), 0);
    chk("w_setup_addr", 32'(tim_paddr), 32'h00C);
    chk("w_setup_data", tim_pwdata, 32'h12345678);
    chk("w_setup_strb", 32'(tim_pstrb), 32'hF);
    chk("w_setup_pwrite", 32'(tim_pwrite), 1);
    chk("w_setup_ready", 32'(cmd_ready), 0);
    tick();
    chk("w_access_pen", 32'(tim_penable), 1);
    chk("w_access_rv", 32'(rsp_valid), 0);
    tick();
    chk("w_rsp_valid", 32'(rsp_valid), 1);
    chk("w_rsp_err", 32'(rsp_err), 0);
    chk("w_rsp_rdata", rsp_rdata, 0);
    chk("w_idle_psel", 32'(tim_psel), 0);
    chk("w_idle_addr", 32'(tim_paddr), 0);
    tick();
    chk("w_rv_pulse", 32'(rsp_valid), 0);
    tim_pready = 1'b0;
    cmd(1'b0, 12'h00C, 32'hAAAAAAAA, 4'hF);
    tick();
    cmd_valid = 1'b0;
    chk("r_strb_zero", 32'(tim_pstrb), 0);
    chk("r_pwrite", 32'(tim_pwrite), 0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (tim_penable) n++;
      chk("r_wait_ready", 32'(cmd_ready), 0);
    end
    tim_pready = 1'b1;
    tim_prdata = 32'h12345678;
    if (tim_penable) n++;
    tick();
    chk("r_pen_cycles", n, 4);
    chk("r_rsp_valid", 32'(rsp_valid), 1);
    chk("r_rdata", rsp_rdata, 32'h12345678);
    tim_prdata = 32'hCAFEF00D;
    tick();
    chk("r_rdata_hold", rsp_rdata, 32'h12345678);
    chk("r_rv_pulse", 32'(rsp_valid), 0);
    cmd(1'b1, 12'h00C, 32'h11111111, 4'hF);
    tick();
    cmd(1'b1, 12'h010, 32'h22222222, 4'h3);
    tick();
    chk("b2b_first_addr", 32'(tim_paddr), 32'h00C);
    chk("b2b_first_pen", 32'(tim_penable), 1);
    chk("b2b_ready", 32'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
    chk("b2b_psel_held", 32'(tim_psel), 1);
    chk("b2b_pen_drop", 32'(tim_penable), 0);
    chk("b2b_second_addr", 32'(tim_paddr), 32'h010);
    chk("b2b_second_data", tim_pwdata, 32'h22222222);
    chk("b2b_rv1", 32'(rsp_valid), 1);
    tick();
    chk("b2b_second_pen", 32'(tim_penable), 1);
    chk("b2b_rv_gap", 32'(rsp_valid), 0);
    tick();
    chk("b2b_rv2", 32'(rsp_valid), 1);
    chk("b2b_done_psel", 32'(tim_psel), 0);
    tim_pslverr = 1'b1;
    tim_prdata = 32'hDEADBEEF;
    cmd(1'b0, 12'h020, 32'h0, 4'h0);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("err_rv", 32'(rsp_valid), 1);
    chk("err_err", 32'(rsp_err), 1);
    chk("err_rdata", rsp_rdata, 0);
    chk("err_to", 32'(rsp_timeout), 0);
    tim_pslverr = 1'b0;
    tim_pready = 1'b0;
    cmd(1'b0, 12'h030, 32'h0, 4'h0);
    tick();
    cmd_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && !rsp_valid; i++) begin
      if (tim_penable) n++;
      tick();
    end
    chk("to_rv", 32'(rsp_valid), 1);
    chk("to_access_cycles", n, 16);
    chk("to_err", 32'(rsp_err), 1);
    chk("to_timeout", 32'(rsp_timeout), 1);
    chk("to_rdata", rsp_rdata, 0);
    chk("to_psel", 32'(tim_psel), 0);
    tick();
    chk("to_pulse", 32'(rsp_timeout), 0);
    chk("to_err_hold", 32'(rsp_err), 1);
    tim_pready = 1'b1;
    cmd(1'b1, 12'h040, 32'h55AA55AA, 4'hF);
    tick();
    cmd_valid = 1'b0;
    chk("after_to_addr", 32'(tim_paddr), 32'h040);
    tick();
    tick();
    chk("after_to_rv", 32'(rsp_valid), 1);
    chk("after_to_err", 32'(rsp_err), 0);
    tim_pready = 1'b0;
    cmd(1'b1, 12'h050, 32'h77777777, 4'hF);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rst_mid_pen_before", 32'(tim_penable), 1);
    sys_rst = 1'b1;
    #1;
    chk("rst_mid_psel", 32'(tim_psel), 0);
    chk("rst_mid_pen", 32'(tim_penable), 0);
    chk("rst_mid_addr", 32'(tim_paddr), 0);
    chk("rst_mid_ready", 32'(cmd_ready), 0);
    tick();
    chk("rst_mid_rv", 32'(rsp_valid), 0);
    sys_rst = 1'b0;
    tim_pready = 1'b1;
    tick();
    chk("no_replay_psel", 32'(tim_psel), 0);
    cmd(1'b1, 12'h010, 32'h33333333, 4'hF);
    tick();
    cmd_valid = 1'b0;
    chk("post_rst_addr", 32'(tim_paddr), 32'h010);
    tick();
    tick();
    chk("post_rst_rv", 32'(rsp_valid), 1);
    chk("post_rst_err", 32'(rsp_err), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 Parameter TIMEOUT, default 16: ACCESS-phase wait-cycle limit; 0 disables the timeout.
REQ-002 Parameter ADDR_W, default 12: APB address width.
REQ-003 sys_clk  input  1  single clock; all state updates on rising edge.
REQ-004 sys_rst  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  request present.
REQ-006 cmd_ready  output  1  request accepted when cmd_valid&cmd_ready at a rising edge.
REQ-007 cmd_write  input  1  1=write, 0=read.
REQ-008 cmd_addr  input  ADDR_W  register offset.
REQ-009 cmd_wdata  input  32  write data.
REQ-010 cmd_strb  input  4  byte strobes; forced to 0 on reads.
REQ-011 rsp_valid  output  1  one-cycle completion pulse; no backpressure.
REQ-012 rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-013 rsp_err  output  1  pslverr or timeout on completed transfer.
REQ-014 rsp_timeout  output  1  error cause was timeout.
REQ-015 tim_psel, tim_penable, tim_pwrite  output  1 each  APB control.
REQ-016 tim_paddr  output  ADDR_W; tim_pwdata  output  32; tim_pstrb  output  4.
REQ-017 tim_pready, tim_pslverr  input  1 each; tim_prdata  input  32.

Function
REQ-018 FSM states IDLE, SETUP, ACCESS; all APB outputs registered.
REQ-019 IDLE: cmd_ready=1; on accept, latch write/addr/wdata/strb onto APB buses, psel=1, penable=0, go SETUP next cycle.
REQ-020 SETUP lasts exactly one cycle, then penable=1, go ACCESS; APB address/data/control stay stable through SETUP and ACCESS.
REQ-021 ACCESS with tim_pready=0: hold all outputs and increment the wait counter.
REQ-022 ACCESS with tim_pready=1: transfer completes; next cycle rsp_valid=1, rsp_err=tim_pslverr, rsp_rdata=tim_prdata for a read without error, else 0.
REQ-023 cmd_ready=1 during an ACCESS cycle with tim_pready=1 (combinational on pready); a command accepted there goes directly to SETUP with psel held 1 and penable 0 (back-to-back, no IDLE cycle).
REQ-024 Completion without a new command: psel=0, penable=0, paddr/pwdata/pstrb/pwrite cleared to 0, go IDLE.
REQ-025 cmd_ready=0 in SETUP and in ACCESS while tim_pready=0.
REQ-026 Timeout: when TIMEOUT!=0 and the wait counter reaches TIMEOUT with pready still 0, abort: psel=penable=0, go IDLE, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-027 Wait counter is 8 bits, saturating; it clears on entry to SETUP.
REQ-028 Latency with zero wait states: accept edge N, SETUP N+1, ACCESS N+2, rsp_valid during cycle N+3.
REQ-029 rsp_valid and rsp_timeout are single-cycle pulses; rsp_rdata/rsp_err hold until the next response.
REQ-030 tim_pready/tim_prdata/tim_pslverr are ignored outside ACCESS.

Reset
REQ-031 sys_rst=1 immediately forces IDLE and sets every output to 0 except cmd_ready, which is 0 while reset is asserted and 1 from the first cycle after deassertion.
REQ-032 Reset mid-transfer drops psel/penable with no rsp_valid; the lost command is not replayed.
REQ-033 The wait counter and latched command clear on reset.

Verification
REQ-034 Write addr 0x0C, data 0x12345678, strb 0xF, pready tied 1 -> psel 1 cycle before penable; rsp_valid 3 cycles after accept with rsp_err=0.
REQ-035 Read 0x0C, slave returns 0x12345678 after 3 wait cycles -> penable held 4 cycles, rsp_rdata=0x12345678.
REQ-036 Back-to-back writes 0x0C/0x11111111 then 0x10/0x22222222 -> psel stays 1 across both, penable drops 1 cycle between them, two rsp_valid pulses.
REQ-037 Read with pslverr=1 -> rsp_err=1, rsp_rdata=0, rsp_timeout=0.
REQ-038 TIMEOUT=16, pready stuck 0 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, psel=0; next command is accepted normally.
REQ-039 Assert sys_rst during ACCESS -> all APB outputs 0 asynchronously, no rsp_valid; after release, a write to 0x10 completes.
